// File: rtl/hci_package.sv
// Shared definitions for the L2 memory bank adapter.
//   bank_state_e   : bank FSM states (zero-fill, then normal traffic)
//   mem_be_width   : number of SRAM byte enables needed to cover {user, data}
//   user_be_width  : how many of those enables belong to the user field
package hci_package;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bank_state_e;

    // SRAM words are packed as {user, data}; a partial top byte still
    // needs its own enable, hence the round-up.
    function automatic int unsigned mem_be_width(input int unsigned dw,
                                                 input int unsigned uw,
                                                 input int unsigned bw);
        return (dw + uw + bw - 1) / bw;
    endfunction

    function automatic int unsigned user_be_width(input int unsigned dw,
                                                  input int unsigned uw,
                                                  input int unsigned bw);
        return mem_be_width(dw, uw, bw) - (dw / bw);
    endfunction

endpackage

// File: rtl/hci_l2_mem_bank_adapter_if.sv
// HCI core request/response bundle between an interconnect memory port and
// a bank adapter.
//   initiator : drives req/add/wen/data/be/user/id, receives gnt and response
//   target    : receives the request, drives gnt and r_data/r_user/r_id/r_valid
// A zero-width user field is carried as a single unused bit.
interface hci_core_intf #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32,
    parameter int unsigned BW = 8,
    parameter int unsigned UW = 0,
    parameter int unsigned IW = 20
);
    localparam int unsigned UW_W = (UW > 0) ? UW : 1;

    logic            req;
    logic            gnt;
    logic [AW-1:0]   add;
    logic            wen;      // 1 = read, 0 = write
    logic [DW-1:0]   data;
    logic [DW/BW-1:0] be;
    logic [UW_W-1:0] user;
    logic [IW-1:0]   id;
    logic [DW-1:0]   r_data;
    logic [UW_W-1:0] r_user;
    logic [IW-1:0]   r_id;
    logic            r_valid;

    modport initiator (
        output req, add, wen, data, be, user, id,
        input  gnt, r_data, r_user, r_id, r_valid
    );

    modport target (
        input  req, add, wen, data, be, user, id,
        output gnt, r_data, r_user, r_id, r_valid
    );
endinterface

// File: rtl/hci_l2_mem_bank_adapter.sv
// Adapts one HCI interconnect memory port to a single-port SRAM bank.
// After reset the bank is optionally zero-filled one word per cycle; then
// every request is granted immediately and answered exactly one cycle later.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   tcdm          : HCI target port (request in, grant/response out)
//   mem_*_o       : SRAM chip enable, write enable, word address, {user,data}, byte enables
//   mem_rdata_i   : SRAM read data, valid the cycle after a read enable
//   init_done_o   : bank accepts traffic
//   err_o         : sticky out-of-range access flag
module hci_l2_mem_bank_adapter
    import hci_package::*;
#(
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned BW        = 8,
    parameter int unsigned UW        = 0,
    parameter int unsigned IW        = 20,
    parameter int unsigned N_WORDS   = 4096,
    parameter int unsigned INIT_ZERO = 1,
    localparam int unsigned MAW      = (N_WORDS > 1) ? $clog2(N_WORDS) : 1,
    localparam int unsigned MW       = DW + UW,
    localparam int unsigned MBEW     = mem_be_width(DW, UW, BW)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    hci_core_intf.target    tcdm,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [MAW-1:0]  mem_addr_o,
    output logic [MW-1:0]   mem_wdata_o,
    output logic [MBEW-1:0] mem_be_o,
    input  logic [MW-1:0]   mem_rdata_i,
    output logic            init_done_o,
    output logic            err_o
);

    localparam int unsigned WIDX_W = AW - 2;
    localparam int unsigned DBEW   = DW / BW;
    // With a power-of-two depth every MAW-bit index exists; upper address
    // bits simply alias onto the bank.
    localparam bit POW2 = (N_WORDS == (1 << MAW));
    localparam logic [WIDX_W-1:0] N_WORDS_IDX = WIDX_W'(N_WORDS);
    localparam logic [MAW-1:0]    LAST_ADDR   = MAW'(N_WORDS - 1);

    bank_state_e        state_q, state_d;
    logic [MAW-1:0]     init_cnt_q;
    logic [WIDX_W-1:0]  word_idx;
    logic               in_range;
    logic               gnt;
    logic               accept;
    logic [MW-1:0]      run_wdata;
    logic [MBEW-1:0]    run_be;

    logic               r_valid_q;
    logic [IW-1:0]      r_id_q;
    logic               rd_q;       // response in flight carries SRAM read data
    logic               oor_q;      // response in flight is for an out-of-range access
    logic [MW-1:0]      hold_q;
    logic [MW-1:0]      resp_data;
    logic               err_q;

    logic               unused_bits;

    assign word_idx    = tcdm.add[AW-1:2];
    assign in_range    = POW2 ? 1'b1 : (word_idx < N_WORDS_IDX);
    assign accept      = tcdm.req & gnt;
    assign unused_bits = ^{tcdm.add[1:0], tcdm.user};

    generate
        if (UW > 0) begin : g_user
            assign run_wdata   = {tcdm.user, tcdm.data};
            assign run_be      = {{user_be_width(DW, UW, BW){1'b1}}, tcdm.be};
            assign tcdm.r_user = resp_data[MW-1:DW];
        end else begin : g_no_user
            assign run_wdata   = tcdm.data;
            assign run_be      = tcdm.be;
            assign tcdm.r_user = '0;
        end
    endgenerate

    // Next state and SRAM/grant outputs.
    always_comb begin
        state_d     = state_q;
        gnt         = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = word_idx[MAW-1:0];
        mem_wdata_o = run_wdata;
        mem_be_o    = run_be;
        case (state_q)
            ST_INIT: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = init_cnt_q;
                mem_wdata_o = '0;
                mem_be_o    = '1;
                if (init_cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                gnt = 1'b1;
                if (tcdm.req && in_range) begin
                    mem_req_o = 1'b1;
                    mem_we_o  = ~tcdm.wen;
                end
            end
            default: state_d = ST_INIT;
        endcase
        // Keep the SRAM and the port quiet while reset is held.
        if (rst_i) begin
            mem_req_o = 1'b0;
            mem_we_o  = 1'b0;
            gnt       = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
            init_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT) begin
                init_cnt_q <= init_cnt_q + 1'b1;
            end
        end
    end

    // The interconnect expects r_valid exactly one cycle after req&gnt.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid_q <= 1'b0;
            r_id_q    <= '0;
            rd_q      <= 1'b0;
            oor_q     <= 1'b0;
            hold_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            r_valid_q <= accept;
            if (accept) begin
                r_id_q <= tcdm.id;
                rd_q   <= tcdm.wen & in_range;
                oor_q  <= ~in_range;
            end
            if (r_valid_q && rd_q) begin
                hold_q <= mem_rdata_i;
            end
            if (accept && !in_range) begin
                err_q <= 1'b1;
            end
        end
    end

    // Live SRAM data on a read response, zero for an out-of-range response,
    // otherwise the last read value is held.
    always_comb begin
        resp_data = hold_q;
        if (r_valid_q) begin
            if (rd_q) begin
                resp_data = mem_rdata_i;
            end else if (oor_q) begin
                resp_data = '0;
            end
        end
    end

    assign tcdm.gnt     = gnt;
    assign tcdm.r_valid = r_valid_q;
    assign tcdm.r_id    = r_id_q;
    assign tcdm.r_data  = resp_data[DW-1:0];
    assign init_done_o  = (state_q == ST_RUN);
    assign err_o        = err_q;

endmodule

// File: doc/hci_l2_mem_bank_adapter.md
HCI_L2_MEM_BANK_ADAPTER -- requirements
Module: hci_l2_mem_bank_adapter

Interface
REQ-001 Parameter AW, 32: byte address width of the HCI target port.
REQ-002 Parameter DW, 32: data width.
REQ-003 Parameter BW, 8: byte width; the byte-enable width is DW/BW.
REQ-004 Parameter UW, 0: user sideband width; user bits are stored alongside data.
REQ-005 Parameter IW, 20: request/response ID width.
REQ-006 Parameter N_WORDS, 4096: bank depth in words; MAW = $clog2(N_WORDS).
REQ-007 Parameter INIT_ZERO, 1: when set, the bank is zero-filled after reset.
REQ-008 clk_i  in  1  single clock; all logic is rising-edge.
REQ-009 rst_i  in  1  reset, asynchronous and active-high.
REQ-010 tcdm  hci_core_intf.target  --  request from one interconnect memory port (req, add, wen, data, be, user, id, gnt, r_data, r_user, r_id, r_valid).
REQ-011 mem_req_o  out  1  SRAM chip enable.
REQ-012 mem_we_o  out  1  SRAM write enable, high for a write.
REQ-013 mem_addr_o  out  MAW  SRAM word address.
REQ-014 mem_wdata_o  out  DW+UW  SRAM write data, arranged as {user, data}.
REQ-015 mem_be_o  out  (DW+UW)/BW rounded up  SRAM byte enables; the user byte enables are all-ones whenever UW>0.
REQ-016 mem_rdata_i  in  DW+UW  SRAM read data, valid the cycle after a read enable.
REQ-017 init_done_o  out  1  bank is accepting traffic.
REQ-018 err_o  out  1  sticky out-of-range access flag.

Function
REQ-019 The FSM shall have the states INIT and RUN; reset enters INIT when INIT_ZERO=1 and RUN otherwise.
REQ-020 INIT actions: one write per cycle to addresses 0..N_WORDS-1, with wdata='0, be all-ones, mem_req_o=1, mem_we_o=1, tcdm.gnt=0.
REQ-021 INIT exit: after the write to N_WORDS-1, the FSM goes to RUN on the next edge and init_done_o rises in that same cycle; INIT lasts exactly N_WORDS cycles.
REQ-022 RUN grant: tcdm.gnt=1 combinationally; no back-pressure is applied.
REQ-023 RUN in-range handshake: in the cycle with tcdm.req=1 and word index add[MAW+1:2] < N_WORDS, mem_req_o=1, mem_we_o=~tcdm.wen, mem_addr_o=add[MAW+1:2], and data/be are passed through. The wen polarity is 1=read.
REQ-024 Response latency: exactly 1 cycle, because the upstream interconnect derives r_valid as a one-cycle delay of req&gnt. r_valid and r_id shall be registered from req&gnt and id.
REQ-025 Read response: {r_user, r_data} = mem_rdata_i in the response cycle, and that value shall also be captured into a hold register.
REQ-026 Write or idle cycles: {r_user, r_data} shall present the hold register value, stable until the next read response.
REQ-027 Out-of-range request: granted, mem_req_o=0, the response is r_valid=1 with r_data=0 and r_user=0, and err_o is set and stays set until reset.
REQ-028 MAW width rule: when N_WORDS is a power of two, the index is always in range and err_o stays 0.
REQ-029 tcdm.add[1:0] shall be ignored.
REQ-030 Address bits above MAW+1 shall only participate in the range check.
REQ-031 Back-to-back requests shall be accepted every cycle, with one response per cycle in request order.
REQ-032 A request arriving in the last INIT cycle shall not be granted; it is granted in the first RUN cycle.

Reset
REQ-033 Reset mid-INIT or mid-RUN shall abort immediately and restart the fill from address 0.
REQ-034 Reset values: r_valid=0, r_id=0, hold register=0, err_o=0, init_done_o=INIT_ZERO?0:1, mem_req_o=0.
REQ-035 No response shall be issued for a request granted in the cycle reset asserts.

Structure
REQ-036 The FSM state enum and the wdata/be packing helper shall live in hci_package.
REQ-037 The block shall contain no sub-module; the SRAM macro is instantiated by the parent, one adapter per interconnect memory port.

Verification
REQ-038 N_WORDS=16, INIT_ZERO=1, release reset: 16 zero-writes to addresses 0..15, gnt=0 throughout, init_done_o rises in cycle 17.
REQ-039 Write 0xDEADBEEF with be=0b0101 to word 3, then read word 3 over a prefilled-zero SRAM model: r_valid exactly 1 cycle after each grant, read r_data=0x00AD00EF, r_id echoed.
REQ-040 Back-to-back reads of words 0,1,2 with ids 5,6,7: three consecutive r_valid cycles with r_id 5,6,7 and matching data; the following idle cycle holds word 2 data.
REQ-041 N_WORDS=12, read word 13: gnt=1, mem_req_o=0, r_data=0, err_o=1, and err_o still 1 after 100 idle cycles.
REQ-042 Assert rst_i at INIT address 7 for 1 cycle: after release, the fill restarts at 0 and init_done_o is delayed by the full N_WORDS cycles.
REQ-043 Request held during the last INIT cycle: gnt=0 in that cycle and gnt=1 on the next; exactly one response.
